// File: rtl/duck_hit_tracker.sv
// duck_hit_tracker: qualifies bullet/duck collisions, sequences the duck
// through fly/hit/fall/respawn and keeps the BCD score and shot count.
module duck_hit_tracker #(
    parameter int SHOTS_PER_ROUND = 3,
    parameter int SHOT_FRAMES     = 8,
    parameter int HIT_FRAMES      = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        fire,
    input  logic        collision,
    input  logic        duck_landed,
    input  logic        duck_escaped,
    output logic [1:0]  duck_state,
    output logic        shot_active,
    output logic [1:0]  shots_left,
    output logic [15:0] score_bcd,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        escape_pulse,
    output logic        respawn
);

    typedef enum logic [1:0] {
        FLYING  = 2'd0,
        HIT     = 2'd1,
        FALLING = 2'd2,
        RESPAWN = 2'd3
    } state_e;

    localparam logic [1:0] SHOTS_INIT = 2'(SHOTS_PER_ROUND);
    localparam logic [7:0] SHOT_LD    = 8'(SHOT_FRAMES);
    localparam logic [7:0] HIT_LD     = 8'(HIT_FRAMES);

    state_e      state_q;
    logic        active_q;
    logic [1:0]  shots_q;
    logic [15:0] score_q;
    logic [15:0] score_d;
    logic [7:0]  shot_cnt_q;
    logic [7:0]  hit_cnt_q;
    logic        hit_q;
    logic        miss_q;
    logic        esc_q;
    logic        resp_q;

    logic hit_w;
    logic miss_w;
    logic esc_w;
    logic fire_ok_w;

    // Saturating four-digit BCD increment with ripple carry between digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign score_d   = bcd_inc(score_q);
    assign hit_w     = active_q && collision;
    assign miss_w    = active_q && frame_tick && (shot_cnt_q == 8'd1);
    assign esc_w     = duck_escaped || (shots_q == 2'd0 && !active_q);
    assign fire_ok_w = fire && !active_q && (shots_q != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FLYING;
            active_q   <= 1'b0;
            shots_q    <= SHOTS_INIT;
            score_q    <= 16'h0000;
            shot_cnt_q <= 8'd0;
            hit_cnt_q  <= 8'd0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            esc_q      <= 1'b0;
            resp_q     <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            esc_q  <= 1'b0;
            resp_q <= 1'b0;
            unique case (state_q)
                FLYING: begin
                    if (hit_w) begin
                        state_q    <= HIT;
                        active_q   <= 1'b0;
                        shot_cnt_q <= 8'd0;
                        hit_q      <= 1'b1;
                        score_q    <= score_d;
                        hit_cnt_q  <= HIT_LD;
                    end else if (miss_w) begin
                        active_q   <= 1'b0;
                        shot_cnt_q <= 8'd0;
                        miss_q     <= 1'b1;
                    end else if (esc_w) begin
                        // A live shot dies with the departing duck.
                        state_q    <= RESPAWN;
                        active_q   <= 1'b0;
                        shot_cnt_q <= 8'd0;
                        esc_q      <= 1'b1;
                        resp_q     <= 1'b1;
                    end else if (fire_ok_w) begin
                        shots_q    <= shots_q - 2'd1;
                        active_q   <= 1'b1;
                        shot_cnt_q <= SHOT_LD;
                    end else if (active_q && frame_tick) begin
                        shot_cnt_q <= shot_cnt_q - 8'd1;
                    end
                end
                HIT: begin
                    if (frame_tick) begin
                        hit_cnt_q <= hit_cnt_q - 8'd1;
                        if (hit_cnt_q == 8'd1) begin
                            state_q <= FALLING;
                        end
                    end
                end
                FALLING: begin
                    if (duck_landed) begin
                        state_q <= RESPAWN;
                        resp_q  <= 1'b1;
                    end
                end
                RESPAWN: begin
                    state_q <= FLYING;
                    shots_q <= SHOTS_INIT;
                end
            endcase
        end
    end

    assign duck_state   = state_q;
    assign shot_active  = active_q;
    assign shots_left   = shots_q;
    assign score_bcd    = score_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;
    assign escape_pulse = esc_q;
    assign respawn      = resp_q;

endmodule
